// File: rtl/smpl_seq_buf.sv
// Circular sample buffer feeding the FIR MAC core: keeps the last DEPTH samples and,
// once full, replays them oldest-first on every new sample while sequencing is high.
module smpl_seq_buf #(
    parameter int unsigned DEPTH  = 1021,
    parameter int unsigned ADDR_W = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wrt_smpl,
    input  logic signed [15:0] smpl_in,
    output logic               sequencing,
    output logic signed [15:0] smpl_out,
    output logic               full
);

    typedef enum logic [1:0] {StIdle, StPrime, StSeq} state_t;

    localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   CntFull = (ADDR_W + 1)'(DEPTH);

    function automatic logic [ADDR_W-1:0] wrap_inc(input logic [ADDR_W-1:0] p);
        return (p == LastIdx) ? '0 : p + 1'b1;
    endfunction

    logic signed [15:0] r_mem [DEPTH];
    logic signed [15:0] r_rd_data;

    state_t              r_state, w_state_nxt;
    logic [ADDR_W-1:0]   r_new_ptr, w_new_ptr_nxt;
    logic [ADDR_W-1:0]   r_rd_ptr, w_rd_ptr_nxt;
    logic [ADDR_W-1:0]   r_seq_cnt, w_seq_cnt_nxt;
    logic [ADDR_W:0]     r_cnt, w_cnt_nxt;
    logic                r_pend, w_pend_nxt;
    logic                r_sequencing;
    logic signed [15:0]  r_smpl_out;
    logic                w_trig;

    // Storage is left unreset so it maps onto block RAM; reads have one cycle of latency.
    always_ff @(posedge clk) begin
        if (wrt_smpl) begin
            r_mem[r_new_ptr] <= smpl_in;
        end
        r_rd_data <= r_mem[r_rd_ptr];
    end

    always_comb begin
        w_new_ptr_nxt = wrt_smpl ? wrap_inc(r_new_ptr) : r_new_ptr;
        w_cnt_nxt     = (wrt_smpl && (r_cnt != CntFull)) ? r_cnt + 1'b1 : r_cnt;
        w_trig        = wrt_smpl && (w_cnt_nxt == CntFull);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A write landing while a window is in flight (including its last cycle) becomes pend.
    always_comb begin
        w_state_nxt   = r_state;
        w_rd_ptr_nxt  = r_rd_ptr;
        w_seq_cnt_nxt = r_seq_cnt;
        w_pend_nxt    = r_pend;
        case (r_state)
            StIdle: begin
                if (w_trig) begin
                    w_state_nxt  = StPrime;
                    w_rd_ptr_nxt = w_new_ptr_nxt;
                end
            end
            StPrime: begin
                w_rd_ptr_nxt  = wrap_inc(r_rd_ptr);
                w_seq_cnt_nxt = '0;
                w_state_nxt   = StSeq;
                if (w_trig) begin
                    w_pend_nxt = 1'b1;
                end
            end
            StSeq: begin
                w_rd_ptr_nxt = wrap_inc(r_rd_ptr);
                if (r_seq_cnt == LastIdx) begin
                    w_seq_cnt_nxt = '0;
                    if (r_pend || w_trig) begin
                        w_state_nxt  = StPrime;
                        w_rd_ptr_nxt = w_new_ptr_nxt;
                        w_pend_nxt   = 1'b0;
                    end else begin
                        w_state_nxt = StIdle;
                    end
                end else begin
                    w_seq_cnt_nxt = r_seq_cnt + 1'b1;
                    if (w_trig) begin
                        w_pend_nxt = 1'b1;
                    end
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_new_ptr    <= '0;
            r_rd_ptr     <= '0;
            r_seq_cnt    <= '0;
            r_cnt        <= '0;
            r_pend       <= 1'b0;
            r_sequencing <= 1'b0;
            r_smpl_out   <= '0;
        end else begin
            r_new_ptr    <= w_new_ptr_nxt;
            r_rd_ptr     <= w_rd_ptr_nxt;
            r_seq_cnt    <= w_seq_cnt_nxt;
            r_cnt        <= w_cnt_nxt;
            r_pend       <= w_pend_nxt;
            r_sequencing <= (r_state == StSeq);
            if (r_state == StSeq) begin
                r_smpl_out <= r_rd_data;
            end
        end
    end

    assign sequencing = r_sequencing;
    assign smpl_out   = r_smpl_out;
    assign full       = (r_cnt == CntFull);

endmodule

// File: tb/tb_smpl_seq_buf.sv
// Directed bench for smpl_seq_buf: an 8-deep instance for window/pend/reset behaviour
// and a default 1021-deep instance for full-length windows and signed extremes.
module tb_smpl_seq_buf;

    logic        clk = 1'b0;
    logic        a_rst_n, a_wrt, a_seq, a_full;
    logic [15:0] a_in, a_out;
    logic        b_rst_n, b_wrt, b_seq, b_full;
    logic [15:0] b_in, b_out;

    int          n_vec = 0;
    int          n_err = 0;
    logic [15:0] ew [8];

    always #5 clk = ~clk;

    smpl_seq_buf #(.DEPTH(8), .ADDR_W(3)) u_dut_a (
        .clk        (clk),
        .rst_n      (a_rst_n),
        .wrt_smpl   (a_wrt),
        .smpl_in    (a_in),
        .sequencing (a_seq),
        .smpl_out   (a_out),
        .full       (a_full)
    );

    smpl_seq_buf u_dut_b (
        .clk        (clk),
        .rst_n      (b_rst_n),
        .wrt_smpl   (b_wrt),
        .smpl_in    (b_in),
        .sequencing (b_seq),
        .smpl_out   (b_out),
        .full       (b_full)
    );

    task automatic chk1(input string tag, input logic obs, input logic exp_v);
        n_vec++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp_v);
        end
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        n_vec++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic set_ew(input logic [15:0] e0, e1, e2, e3, e4, e5, e6, e7);
        ew[0] = e0; ew[1] = e1; ew[2] = e2; ew[3] = e3;
        ew[4] = e4; ew[5] = e5; ew[6] = e6; ew[7] = e7;
    endtask

    task automatic set_ew_ramp(input logic [15:0] first);
        for (int k = 0; k < 8; k++) ew[k] = first + 16'(k);
    endtask

    task automatic wr_a(input logic [15:0] v);
        a_wrt = 1'b1;
        a_in  = v;
        @(negedge clk);
        a_wrt = 1'b0;
    endtask

    task automatic idle_a(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk1($sformatf("%s_idle%0d", tag, i), a_seq, 1'b0);
        end
    endtask

    // Triggering write; returns at the first sequencing cycle (T+2).
    task automatic fire_a(input string tag, input logic [15:0] v);
        wr_a(v);
        chk1({tag, "_full"}, a_full, 1'b1);
        chk1({tag, "_lat0"}, a_seq, 1'b0);
        @(negedge clk);
        chk1({tag, "_lat1"}, a_seq, 1'b0);
        @(negedge clk);
    endtask

    // Checks one 8-cycle window against ew; optional writes after observing cycles k1/k2/k3.
    task automatic win_a(input string tag, input int k1, input logic [15:0] v1,
                         input int k2, input logic [15:0] v2,
                         input int k3, input logic [15:0] v3);
        for (int k = 0; k < 8; k++) begin
            chk1($sformatf("%s_seq%0d", tag, k), a_seq, 1'b1);
            chk16($sformatf("%s_out%0d", tag, k), a_out, ew[k]);
            if (k == k1) begin a_wrt = 1'b1; a_in = v1; end
            else if (k == k2) begin a_wrt = 1'b1; a_in = v2; end
            else if (k == k3) begin a_wrt = 1'b1; a_in = v3; end
            @(negedge clk);
            a_wrt = 1'b0;
        end
        chk1({tag, "_end"}, a_seq, 1'b0);
        chk16({tag, "_hold"}, a_out, ew[7]);
    endtask

    function automatic logic [15:0] bval(input int k);
        if (k == 0) return 16'h8000;
        if (k == 1) return 16'h7FFF;
        return 16'(k);
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        a_rst_n = 1'b0; a_wrt = 1'b0; a_in = '0;
        b_rst_n = 1'b0; b_wrt = 1'b0; b_in = '0;
        repeat (2) @(negedge clk);
        chk1("rst_seq", a_seq, 1'b0);
        chk16("rst_out", a_out, 16'h0000);
        chk1("rst_full", a_full, 1'b0);
        chk1("rst_b_seq", b_seq, 1'b0);
        chk1("rst_b_full", b_full, 1'b0);
        a_rst_n = 1'b1;
        b_rst_n = 1'b1;
        @(negedge clk);

        // Fill: no window before the 8th write.
        for (int i = 1; i <= 7; i++) begin
            wr_a(16'(i));
            chk1($sformatf("fill%0d_full", i), a_full, 1'b0);
            chk1($sformatf("fill%0d_seq", i), a_seq, 1'b0);
            idle_a($sformatf("fill%0d", i), 11);
        end
        fire_a("w8", 16'd8);
        set_ew_ramp(16'd1);
        win_a("w8", -1, '0, -1, '0, -1, '0);
        idle_a("w8", 4);

        // Steady state, new_ptr wraps 7->0.
        for (int v = 9; v <= 11; v++) begin
            fire_a($sformatf("w%0d", v), 16'(v));
            set_ew_ramp(16'(v - 7));
            win_a($sformatf("w%0d", v), -1, '0, -1, '0, -1, '0);
            idle_a($sformatf("w%0d", v), 4);
        end

        // Write mid-window: current window intact, one idle cycle, next ends with 20.
        fire_a("w12", 16'd12);
        set_ew_ramp(16'd5);
        win_a("w12", 3, 16'd20, -1, '0, -1, '0);
        @(negedge clk);
        set_ew(16'd6, 16'd7, 16'd8, 16'd9, 16'd10, 16'd11, 16'd12, 16'd20);
        win_a("p20", -1, '0, -1, '0, -1, '0);
        idle_a("p20", 4);

        // Three writes in one window collapse into a single extra window.
        fire_a("w21", 16'd21);
        set_ew(16'd7, 16'd8, 16'd9, 16'd10, 16'd11, 16'd12, 16'd20, 16'd21);
        win_a("w21", 1, 16'd30, 3, 16'd31, 5, 16'd32);
        @(negedge clk);
        set_ew(16'd10, 16'd11, 16'd12, 16'd20, 16'd21, 16'd30, 16'd31, 16'd32);
        win_a("p32", -1, '0, -1, '0, -1, '0);
        idle_a("p32", 12);

        // Reset mid-window.
        fire_a("w40", 16'd40);
        chk1("w40_seq0", a_seq, 1'b1);
        @(negedge clk);
        a_rst_n = 1'b0;
        #1;
        chk1("mrst_seq", a_seq, 1'b0);
        chk16("mrst_out", a_out, 16'h0000);
        chk1("mrst_full", a_full, 1'b0);
        @(negedge clk);
        a_rst_n = 1'b1;
        idle_a("mrst", 2);
        for (int i = 0; i < 7; i++) begin
            wr_a(16'(50 + i));
            chk1($sformatf("refill%0d_full", i), a_full, 1'b0);
            chk1($sformatf("refill%0d_seq", i), a_seq, 1'b0);
            idle_a($sformatf("refill%0d", i), 11);
        end
        fire_a("w57", 16'd57);
        set_ew_ramp(16'd50);
        win_a("w57", -1, '0, -1, '0, -1, '0);
        idle_a("w57", 3);

        // Default depth: full-length window, signed extremes first.
        for (int k = 0; k < 1021; k++) begin
            b_wrt = 1'b1;
            b_in  = bval(k);
            @(negedge clk);
            b_wrt = 1'b0;
            chk1($sformatf("b_fill%0d_full", k), b_full, (k == 1020));
            chk1($sformatf("b_fill%0d_seq", k), b_seq, 1'b0);
            @(negedge clk);
            chk1($sformatf("b_fill%0d_seq1", k), b_seq, 1'b0);
        end
        @(negedge clk);
        for (int k = 0; k < 1021; k++) begin
            chk1($sformatf("b_seq%0d", k), b_seq, 1'b1);
            chk16($sformatf("b_out%0d", k), b_out, bval(k));
            @(negedge clk);
        end
        chk1("b_end", b_seq, 1'b0);
        chk16("b_hold", b_out, 16'd1020);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
